// File: rtl/usb_bus_state_det.sv
// Full-speed USB bus condition detector: synchronises and filters D+/D-,
// then tracks bus reset, suspend and resume from how long the filtered state dwells.
module usb_bus_state_det #(
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 3,
  parameter int RESET_DET_CYCLES  = 120,
  parameter int SUSPEND_CYCLES    = 144000,
  parameter int RESUME_CYCLES     = 960,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  input  logic       usb_tx_en,
  output logic [1:0] line_state,
  output logic       usb_reset,
  output logic       usb_reset_pulse,
  output logic       suspend,
  output logic       resume_pulse
);

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;

  localparam logic [1:0] ST_ACTIVE    = 2'd0;
  localparam logic [1:0] ST_BUS_RESET = 2'd1;
  localparam logic [1:0] ST_SUSPENDED = 2'd2;
  localparam logic [1:0] ST_RESUMING  = 2'd3;

  localparam int MAX_AB = (SUSPEND_CYCLES > RESUME_CYCLES) ? SUSPEND_CYCLES : RESUME_CYCLES;
  localparam int MAX_C  = (MAX_AB > RESET_DET_CYCLES) ? MAX_AB : RESET_DET_CYCLES;
  localparam int DW     = $clog2(MAX_C) + 1;
  localparam int FW     = $clog2(FILTER_CYCLES + 1);
  localparam int HW     = $clog2(RESET_HOLD_CYCLES + 2);
  localparam int BW     = $clog2(SYNC_STAGES + 1);

  localparam logic [DW-1:0] DWELL_MAX = {DW{1'b1}};
  localparam logic [DW-1:0] RST_N     = DW'(RESET_DET_CYCLES);
  localparam logic [DW-1:0] SUSP_N    = DW'(SUSPEND_CYCLES);
  localparam logic [DW-1:0] RES_N     = DW'(RESUME_CYCLES);
  localparam logic [FW-1:0] FILT_N    = FW'(FILTER_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_N    = HW'(RESET_HOLD_CYCLES);
  localparam logic [BW-1:0] BLANK_N   = BW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] r_p_sync;
  logic [SYNC_STAGES-1:0] r_n_sync;
  logic [BW-1:0]          r_blank_cnt;
  logic [1:0]             r_cand;
  logic [FW-1:0]          r_fcnt;
  logic [1:0]             r_line;
  logic [DW-1:0]          r_dwell;
  logic [HW-1:0]          r_hold;
  logic [1:0]             r_state;
  logic                   r_usb_reset;
  logic                   r_usb_reset_pulse;
  logic                   r_suspend;
  logic                   r_resume_pulse;

  logic                   w_blank;
  logic [1:0]             w_raw;
  logic [1:0]             w_line_nxt;
  logic [1:0]             w_state_nxt;
  logic                   w_go;
  logic                   w_se0_hit;
  logic                   w_j_hit;
  logic                   w_k_hit;

  // Sync stage: flops preset to J so a reset never looks like a line event
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p_sync <= {SYNC_STAGES{1'b1}};
      r_n_sync <= '0;
    end else begin
      r_p_sync <= {r_p_sync[SYNC_STAGES-2:0], usb_p_rx};
      r_n_sync <= {r_n_sync[SYNC_STAGES-2:0], usb_n_rx};
    end
  end

  // Our own transmission is still draining through the synchroniser for SYNC_STAGES cycles
  always_ff @(posedge clk) begin
    if (reset)
      r_blank_cnt <= '0;
    else if (usb_tx_en)
      r_blank_cnt <= BLANK_N;
    else if (r_blank_cnt != '0)
      r_blank_cnt <= r_blank_cnt - BW'(1);
  end

  assign w_blank = usb_tx_en || (r_blank_cnt != '0);
  assign w_raw   = w_blank ? LS_J : {r_n_sync[SYNC_STAGES-1], r_p_sync[SYNC_STAGES-1]};

  // Filter stage: accept a new state on its FILTER_CYCLES-th consecutive sample
  always_comb begin
    w_line_nxt = r_line;
    if (w_raw != r_cand) begin
      if (FILTER_CYCLES == 1)
        w_line_nxt = w_raw;
    end else if (r_fcnt >= FILT_LAST) begin
      w_line_nxt = r_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= LS_J;
      r_fcnt <= '0;
      r_line <= LS_J;
    end else begin
      r_line <= w_line_nxt;
      if (w_raw != r_cand) begin
        r_cand <= w_raw;
        r_fcnt <= FW'(1);
      end else if (r_fcnt != FILT_N) begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  assign w_se0_hit = (r_line == LS_SE0) && (r_dwell >= RST_N);
  assign w_j_hit   = (r_line == LS_J)   && (r_dwell >= SUSP_N);
  assign w_k_hit   = (r_line == LS_K)   && (r_dwell >= RES_N);

  always_comb begin
    w_state_nxt = r_state;
    if (!w_blank) begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_se0_hit)    w_state_nxt = ST_BUS_RESET;
          else if (w_j_hit) w_state_nxt = ST_SUSPENDED;
        end
        ST_BUS_RESET: begin
          if ((r_line != LS_SE0) && (r_hold >= HOLD_N)) w_state_nxt = ST_ACTIVE;
        end
        ST_SUSPENDED: begin
          if (w_se0_hit)    w_state_nxt = ST_BUS_RESET;
          else if (w_k_hit) w_state_nxt = ST_RESUMING;
        end
        default: begin
          if (w_se0_hit)              w_state_nxt = ST_BUS_RESET;
          else if (r_line == LS_J)    w_state_nxt = ST_ACTIVE;
        end
      endcase
    end
  end

  assign w_go = (w_state_nxt != r_state);

  // Dwell/FSM stage: hold counts cycles spent in BUS_RESET including the entry cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell           <= '0;
      r_hold            <= '0;
      r_state           <= ST_ACTIVE;
      r_usb_reset       <= 1'b0;
      r_usb_reset_pulse <= 1'b0;
      r_suspend         <= 1'b0;
      r_resume_pulse    <= 1'b0;
    end else begin
      if (w_blank || w_go || (w_line_nxt != r_line))
        r_dwell <= '0;
      else if (r_dwell != DWELL_MAX)
        r_dwell <= r_dwell + DW'(1);

      if (w_go)
        r_hold <= HW'(1);
      else if ((r_state == ST_BUS_RESET) && (r_hold != HOLD_N))
        r_hold <= r_hold + HW'(1);

      r_state           <= w_state_nxt;
      r_usb_reset       <= (w_state_nxt == ST_BUS_RESET);
      r_usb_reset_pulse <= (w_state_nxt == ST_BUS_RESET) && (r_state != ST_BUS_RESET);
      r_suspend         <= (w_state_nxt == ST_SUSPENDED);
      r_resume_pulse    <= (w_state_nxt == ST_RESUMING) && (r_state == ST_SUSPENDED);
    end
  end

  assign line_state      = r_line;
  assign usb_reset       = r_usb_reset;
  assign usb_reset_pulse = r_usb_reset_pulse;
  assign suspend         = r_suspend;
  assign resume_pulse    = r_resume_pulse;

endmodule

// File: tb/tb_usb_bus_state_det.sv
// Scoreboard bench for usb_bus_state_det: stimulus queues expected output
// transitions with their cycle numbers, the monitor matches each observed change.
module tb_usb_bus_state_det;

  localparam int K_LS   = 0;
  localparam int K_RST  = 1;
  localparam int K_RP   = 2;
  localparam int K_SUSP = 3;
  localparam int K_RESP = 4;

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;

  typedef struct packed {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       usb_p_rx;
  logic       usb_n_rx;
  logic       usb_tx_en;
  logic [1:0] line_state;
  logic       usb_reset;
  logic       usb_reset_pulse;
  logic       suspend;
  logic       resume_pulse;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  logic mon_en = 1'b0;
  logic mon_init = 1'b0;
  logic done = 1'b0;
  int  cur[5];
  int  prev[5];
  int  rexp[5] = '{1, 0, 0, 0, 0};

  usb_bus_state_det #(
    .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_DET_CYCLES(8),
    .SUSPEND_CYCLES(40), .RESUME_CYCLES(10), .RESET_HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx),
    .usb_tx_en(usb_tx_en), .line_state(line_state), .usb_reset(usb_reset),
    .usb_reset_pulse(usb_reset_pulse), .suspend(suspend), .resume_pulse(resume_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_LS:    return "line_state";
      K_RST:   return "usb_reset";
      K_RP:    return "usb_reset_pulse";
      K_SUSP:  return "suspend";
      default: return "resume_pulse";
    endcase
  endfunction

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] ls, input logic tx, input int n);
    for (int i = 0; i < n; i++) begin
      usb_p_rx  = ls[0];
      usb_n_rx  = ls[1];
      usb_tx_en = tx;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output change must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en) begin
      cur[K_LS]   = int'(line_state);
      cur[K_RST]  = int'(usb_reset);
      cur[K_RP]   = int'(usb_reset_pulse);
      cur[K_SUSP] = int'(suspend);
      cur[K_RESP] = int'(resume_pulse);
      if (!mon_init) begin
        for (int k = 0; k < 5; k++) begin
          n_checks++;
          if (cur[k] == rexp[k]) n_pass++;
          else $display("FAIL reset_%s: got %0d, expected %0d", kname(k), cur[k], rexp[k]);
          prev[k] = cur[k];
        end
        mon_init = 1'b1;
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (cur[k] != prev[k]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL unexpected_%s: went to %0d at cycle %0d, no change expected",
                       kname(k), cur[k], cyc);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.kind == k && e.val == cur[k] && e.cyc == cyc) n_pass++;
              else $display("FAIL event_%s: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                            kname(k), kname(k), cur[k], cyc, kname(e.kind), e.val, e.cyc);
            end
            prev[k] = cur[k];
          end
        end
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_events: %0d still pending, expected 0 (next %s=%0d at cycle %0d)",
                      exp_q.size(), kname(exp_q[0].kind), exp_q[0].val, exp_q[0].cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    usb_p_rx = 1'b1;
    usb_n_rx = 1'b0;
    usb_tx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // J idle, then long SE0: reset at +13, falls 5 after J returns
    drive(J, 1'b0, 20);
    t = cyc + 1;
    push(K_LS, 0, t + 4);
    push(K_RST, 1, t + 13);
    push(K_RP, 1, t + 13);
    push(K_RP, 0, t + 14);
    drive(SE0, 1'b0, 30);
    t = cyc + 1;
    push(K_LS, 1, t + 4);
    push(K_RST, 0, t + 5);
    drive(J, 1'b0, 15);

    // 9-cycle SE0: hold stretches usb_reset to exactly 4 cycles
    t = cyc + 1;
    push(K_LS, 0, t + 4);
    push(K_LS, 1, t + 13);
    push(K_RST, 1, t + 13);
    push(K_RP, 1, t + 13);
    push(K_RP, 0, t + 14);
    push(K_RST, 0, t + 17);
    drive(SE0, 1'b0, 9);
    drive(J, 1'b0, 21);

    // 7-cycle SE0 is too short; K glitch inside J is filtered; suspend at J start + 45
    t = cyc + 1;
    push(K_LS, 0, t + 4);
    push(K_LS, 1, t + 11);
    push(K_SUSP, 1, t + 52);
    drive(SE0, 1'b0, 7);
    drive(J, 1'b0, 10);
    drive(K, 1'b0, 2);
    drive(J, 1'b0, 38);

    // Resume from suspend; short SE0 in RESUMING is filtered
    t = cyc + 1;
    push(K_LS, 2, t + 4);
    push(K_SUSP, 0, t + 15);
    push(K_RESP, 1, t + 15);
    push(K_RESP, 0, t + 16);
    push(K_LS, 1, t + 21);
    drive(K, 1'b0, 15);
    drive(SE0, 1'b0, 2);
    drive(J, 1'b0, 13);

    // Transmitting over SE0: nothing happens; J dwell restarts 2 cycles after tx_en falls
    t = cyc + 1;
    push(K_SUSP, 1, t + 142);
    drive(SE0, 1'b1, 100);
    drive(J, 1'b0, 50);

    // SE0 from suspend enters bus reset; block reset mid-reset returns to ACTIVE
    t = cyc + 1;
    push(K_LS, 0, t + 4);
    push(K_RST, 1, t + 13);
    push(K_RP, 1, t + 13);
    push(K_SUSP, 0, t + 13);
    push(K_RP, 0, t + 14);
    drive(SE0, 1'b0, 20);
    t = cyc + 1;
    push(K_LS, 1, t);
    push(K_RST, 0, t);
    push(K_SUSP, 1, t + 41);
    reset = 1'b1;
    drive(J, 1'b0, 1);
    reset = 1'b0;
    drive(J, 1'b0, 50);

    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_timeout: monitor did not finish, expected finish");
    $fatal(1);
  end

endmodule
